// File: rtl/avalon_wb_burst_bridge.sv
// avalon_wb_burst_bridge
//   Bridges an Avalon-MM burst slave port onto a Wishbone B4 registered-
//   feedback master (incrementing bursts, cti=010/111, bte=00).
//
// Parameters
//   DW  : data width (8, 16, 32 or 64)
//   AW  : byte address width
//   BCW : Avalon burstcount width
//
// Ports
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   s_av_*                    : Avalon-MM slave (address, byteenable, read,
//                               write, writedata, burstcount, readdata,
//                               waitrequest, readdatavalid)
//   wbm_*                     : Wishbone master (adr, dat, sel, we, cyc, stb,
//                               cti, bte, dat_i, ack, err, rty)
//   s_av_response_o           : only with AV2WB_RESPONSE_EN; 00 = ack beat,
//                               10 = err beat, qualified by readdatavalid
//
// Optional feature macro: AV2WB_RESPONSE_EN
module avalon_wb_burst_bridge #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int BCW = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     s_av_address_i,
  input  logic [DW/8-1:0]   s_av_byteenable_i,
  input  logic              s_av_read_i,
  input  logic              s_av_write_i,
  input  logic [DW-1:0]     s_av_writedata_i,
  input  logic [BCW-1:0]    s_av_burstcount_i,
  output logic [DW-1:0]     s_av_readdata_o,
  output logic              s_av_waitrequest_o,
  output logic              s_av_readdatavalid_o,
`ifdef AV2WB_RESPONSE_EN
  output logic [1:0]        s_av_response_o,
`endif
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic              wbm_we_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic [2:0]        wbm_cti_o,
  output logic [1:0]        wbm_bte_o,
  input  logic [DW-1:0]     wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  input  logic              wbm_rty_i
);

  localparam int unsigned SH = $clog2(DW/8);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       base_q, base_d;
  logic [DW/8-1:0]     be_q, be_d;
  logic [BCW-1:0]      cnt_q, cnt_d;    // beats remaining
  logic [BCW-1:0]      idx_q, idx_d;    // beats completed
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
`ifdef AV2WB_RESPONSE_EN
  logic [1:0]          resp_q, resp_d;
`endif

  logic beat_done;
  logic last_beat;

  // rty alone completes nothing, so the same beat stays on the bus.
  assign beat_done = wbm_ack_i | wbm_err_i;
  assign last_beat = (cnt_q <= BCW'(1));

  assign wbm_adr_o            = base_q + (AW'(idx_q) << SH);
  assign wbm_cti_o            = (cnt_q > BCW'(1)) ? 3'b010 : 3'b111;
  assign wbm_bte_o            = 2'b00;
  assign s_av_readdata_o      = rdata_q;
  assign s_av_readdatavalid_o = rvalid_q;
`ifdef AV2WB_RESPONSE_EN
  assign s_av_response_o      = resp_q;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
`ifdef AV2WB_RESPONSE_EN
    resp_d   = resp_q;
`endif
    wbm_cyc_o          = 1'b0;
    wbm_stb_o          = 1'b0;
    wbm_we_o           = 1'b0;
    wbm_sel_o          = '0;
    wbm_dat_o          = '0;
    s_av_waitrequest_o = 1'b1;

    case (state_q)
      IDLE: begin
        s_av_waitrequest_o = !s_av_read_i;
        if (s_av_read_i) begin
          base_d  = s_av_address_i;
          be_d    = s_av_byteenable_i;
          cnt_d   = (s_av_burstcount_i == '0) ? BCW'(1) : s_av_burstcount_i;
          idx_d   = '0;
          state_d = READ;
        end else if (s_av_write_i) begin
          // Command only; the first data beat is taken in WRITE.
          base_d  = s_av_address_i;
          cnt_d   = (s_av_burstcount_i == '0) ? BCW'(1) : s_av_burstcount_i;
          idx_d   = '0;
          state_d = WRITE;
        end
      end

      READ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = be_q;
        if (beat_done) begin
          rvalid_d = 1'b1;
          rdata_d  = wbm_dat_i;
`ifdef AV2WB_RESPONSE_EN
          resp_d   = wbm_err_i ? 2'b10 : 2'b00;
`endif
          idx_d    = idx_q + BCW'(1);
          cnt_d    = cnt_q - BCW'(1);
          if (last_beat) state_d = IDLE;
        end
      end

      WRITE: begin
        wbm_cyc_o          = 1'b1;
        wbm_we_o           = 1'b1;
        wbm_stb_o          = s_av_write_i;
        wbm_dat_o          = s_av_writedata_i;
        wbm_sel_o          = s_av_byteenable_i;
        s_av_waitrequest_o = !beat_done;
        if (beat_done && s_av_write_i) begin
          idx_d = idx_q + BCW'(1);
          cnt_d = cnt_q - BCW'(1);
          if (last_beat) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef AV2WB_RESPONSE_EN
      resp_q   <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef AV2WB_RESPONSE_EN
      resp_q   <= resp_d;
`endif
    end
  end

endmodule

// File: doc/avalon_wb_burst_bridge.md
AVALON_WB_BURST_BRIDGE -- requirements
Module: avalon_wb_burst_bridge

Interface
REQ-001 SHALL have parameter DW, default 32, data width; legal values are 8, 16, 32, 64.
REQ-002 SHALL have parameter AW, default 32, byte address width.
REQ-003 SHALL have parameter BCW, default 8, Avalon burstcount width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: wb_clk_i  in  1  clock; wb_rst_i  in  1  reset.
REQ-005 SHALL have the Avalon slave ports: s_av_address_i in AW; s_av_byteenable_i in DW/8; s_av_read_i in 1; s_av_write_i in 1; s_av_writedata_i in DW; s_av_burstcount_i in BCW; s_av_readdata_o out DW; s_av_waitrequest_o out 1; s_av_readdatavalid_o out 1.
REQ-006 SHALL have the Wishbone master ports: wbm_adr_o out AW; wbm_dat_o out DW; wbm_sel_o out DW/8; wbm_we_o out 1; wbm_cyc_o out 1; wbm_stb_o out 1; wbm_cti_o out 3; wbm_bte_o out 2; wbm_dat_i in DW; wbm_ack_i in 1; wbm_err_i in 1; wbm_rty_i in 1.

Function
REQ-007 SHALL implement an FSM with states IDLE, READ and WRITE.
REQ-008 In IDLE, s_av_waitrequest_o SHALL be 0 when s_av_read_i=1 and 1 otherwise.
REQ-009 In IDLE with s_av_read_i=1, the bridge SHALL latch the address, byteenable and burstcount, and SHALL go to READ.
REQ-010 In IDLE with s_av_write_i=1 and s_av_read_i=0, the bridge SHALL latch the address and burstcount, SHALL hold waitrequest=1, and SHALL go to WRITE; no data beat is consumed in that cycle.
REQ-011 If read and write are asserted together in IDLE, read SHALL win.
REQ-012 A latched burstcount of 0 SHALL be treated as 1.
REQ-013 A beat counter SHALL track remaining beats; wbm_adr_o SHALL be the latched base plus beat_index*(DW/8), wrapping modulo 2^AW.
REQ-014 wbm_cti_o SHALL be 010 while more than one beat remains and 111 on the last beat; wbm_bte_o SHALL be 00.
REQ-015 In READ: wbm_cyc_o=wbm_stb_o=1, wbm_we_o=0, wbm_sel_o=latched byteenable, s_av_waitrequest_o=1.
REQ-016 In READ, each wbm_ack_i or wbm_err_i SHALL advance the address and counter, register wbm_dat_i into s_av_readdata_o, and assert s_av_readdatavalid_o for exactly one cycle, one cycle after the ack or err.
REQ-017 In WRITE: wbm_cyc_o=1, wbm_we_o=1, wbm_stb_o=s_av_write_i, wbm_dat_o=s_av_writedata_i, wbm_sel_o=s_av_byteenable_i.
REQ-018 In WRITE, s_av_waitrequest_o SHALL equal !(wbm_ack_i|wbm_err_i); a beat completes on ack or err while s_av_write_i=1.
REQ-019 In either burst state, a wbm_rty_i without ack or err SHALL re-issue the same beat without advancing.
REQ-020 After the last beat completes, the bridge SHALL drop wbm_cyc_o and wbm_stb_o in the next cycle and return to IDLE.
REQ-021 A new command SHALL be accepted no earlier than the cycle after the return to IDLE.

Reset
REQ-022 On wb_rst_i, the state SHALL go to IDLE, including mid-burst, with wbm_cyc_o=wbm_stb_o=0 from the next cycle.
REQ-023 After reset, s_av_readdatavalid_o=0, s_av_readdata_o=0, the beat counter=0, wbm_cti_o=111, and s_av_waitrequest_o=1 until a read is presented.
REQ-024 A readdatavalid pulse pending at reset SHALL be suppressed.

Configuration
REQ-025 With macro AV2WB_RESPONSE_EN defined, the bridge SHALL add port s_av_response_o (out, 2 bits): 00 for a beat completed by ack, 10 for a beat completed by err; it is valid with s_av_readdatavalid_o and resets to 00.
REQ-026 Without AV2WB_RESPONSE_EN, the port SHALL be absent, and err beats SHALL complete exactly like ack beats with no error indication.

Verification
REQ-027 Single read: read, address 0x100, burstcount 1, slave acks with 0xDEADBEEF after 2 cycles -> cti=111, one readdatavalid pulse with 0xDEADBEEF, return to IDLE.
REQ-028 Read burst: address 0x1000, burstcount 4, DW=32 -> wbm_adr_o takes 0x1000, 0x1004, 0x1008 and 0x100C, cti is 010, 010, 010, 111, and four readdatavalid pulses arrive in order.
REQ-029 Write burst: burstcount 3, master deasserts write for 2 cycles before beat 2 -> wbm_stb_o=0 during the gap, cyc held at 1, three acks, and waitrequest low only on ack cycles.
REQ-030 Boundary cases: address 0xFFFFFFFC, burstcount 2 -> second beat at address 0x0; burstcount 0 -> a single beat with cti=111.
REQ-031 Fault cases: rty on beat 1 of a 2-beat read -> beat re-issued at the same address with no extra readdatavalid; wb_rst_i during beat 2 -> cyc=0 next cycle and no readdatavalid.
REQ-032 Macro check: with AV2WB_RESPONSE_EN defined, err on beat 2 of a 3-beat read -> responses are 00, 10, 00.
